// File: rtl/par_ser_pkg.sv
// rtl/par_ser_pkg.sv - shared types and helpers for par_serializer and its bit counter
package par_ser_pkg;

  // Shifter control states
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Ceiling log2 usable in parameter expressions; returns 0 for value <= 1
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  // A requested length of 0 or anything past the register width means a full-width frame
  function automatic int norm_len(input int len, input int width);
    if ((len == 0) || (len > width)) begin
      return width;
    end
    return len;
  endfunction

endpackage

// File: rtl/par_ser_bitcnt.sv
// rtl/par_ser_bitcnt.sv - loadable down-counter with a registered remaining==1 flag
module par_ser_bitcnt #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_one
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_one;

  // Count register plus a look-ahead flag so o_one is a flop output, not a decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_one <= 1'b0;
    end else if (i_clr) begin
      r_cnt <= '0;
      r_one <= 1'b0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
      r_one <= (i_load_val == CNT_W'(1));
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
      r_one <= (r_cnt == CNT_W'(2));
    end
  end

  assign o_one = r_one;

endmodule

// File: rtl/par_serializer.sv
// rtl/par_serializer.sv - parallel-to-serial shifter with load handshake; optional abort via PAR_SERIALIZER_ABORT_EN
module par_serializer
  import par_ser_pkg::*;
#(
  parameter int  WIDTH      = 32,
  parameter bit  LSB_FIRST  = 1'b0,
  parameter bit  IDLE_LEVEL = 1'b0,
  localparam int CNT_W      = clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic [CNT_W-1:0] din_len,
  input  logic             din_valid,
`ifdef PAR_SERIALIZER_ABORT_EN
  input  logic             abort,
`endif
  output logic             din_ready,
  output logic             sout,
  output logic             sout_en,
  output logic             last,
  output logic             busy
);

  localparam logic [WIDTH-1:0] FILL = {WIDTH{IDLE_LEVEL}};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_nxt;
  logic [WIDTH-1:0] w_load_img;
  logic [WIDTH-1:0] w_mask;
  logic [WIDTH-1:0] w_din_m;
  logic             r_sout_en;
  logic             r_busy;
  logic             w_abort;
  logic             w_load;
  logic             w_last;
  logic             w_shifting;
  int               w_len_i;
  logic [CNT_W-1:0] w_len_n;

`ifdef PAR_SERIALIZER_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_len_i    = norm_len(int'(din_len), WIDTH);
  assign w_len_n    = w_len_i[CNT_W-1:0];
  assign w_shifting = (r_state == SHIFT);

  // Ready in IDLE or on a frame's final bit so the next frame follows with no gap
  assign din_ready = ((r_state == IDLE) | w_last) & ~w_abort;
  assign w_load    = din_valid & din_ready;

  // Build the load image: keep din[n-1:0], idle-fill the rest, left-align for MSB-first
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_mask[i] = (i < w_len_i);
    end
    w_din_m = (din & w_mask) | (FILL & ~w_mask);
    if (LSB_FIRST) begin
      w_load_img = w_din_m;
    end else begin
      w_load_img = (w_din_m << (WIDTH - w_len_i)) | (FILL & ~(w_mask << (WIDTH - w_len_i)));
    end
  end

  // One-position shift toward the output end, back-filling with the idle level
  always_comb begin
    if (LSB_FIRST) begin
      w_shift_nxt            = r_shift >> 1;
      w_shift_nxt[WIDTH-1]   = IDLE_LEVEL;
    end else begin
      w_shift_nxt            = r_shift << 1;
      w_shift_nxt[0]         = IDLE_LEVEL;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: leave SHIFT only after the final bit when no new frame is loaded
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_load) begin
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (w_last && !w_load) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    if (w_abort) begin
      w_state_nxt = IDLE;
    end
  end

  // Shift register; after n shifts it holds only idle-level bits, so sout idles naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= FILL;
    end else if (w_abort) begin
      r_shift <= FILL;
    end else if (w_load) begin
      r_shift <= w_load_img;
    end else if (w_shifting) begin
      r_shift <= w_shift_nxt;
    end
  end

  // Registered status flags tracking the upcoming state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sout_en <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_sout_en <= (w_state_nxt == SHIFT);
      r_busy    <= (w_state_nxt == SHIFT);
    end
  end

  par_ser_bitcnt #(
    .CNT_W (CNT_W)
  ) u_bitcnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_abort),
    .i_load     (w_load),
    .i_load_val (w_len_n),
    .i_dec      (w_shifting),
    .o_one      (w_last)
  );

  assign sout    = LSB_FIRST ? r_shift[0] : r_shift[WIDTH-1];
  assign sout_en = r_sout_en;
  assign busy    = r_busy;
  assign last    = w_last;

endmodule

// File: tb/tb_par_serializer.sv
// tb/tb_par_serializer.sv - directed self-checking bench for par_serializer (abort cases with PAR_SERIALIZER_ABORT_EN)
module tb_par_serializer;

  logic        clk;
  logic        rst_n;

  logic [31:0] a_din;
  logic [5:0]  a_len;
  logic        a_valid;
  logic        a_abort;
  logic        a_ready, a_sout, a_en, a_last, a_busy;

  logic [7:0]  b_din;
  logic [3:0]  b_len;
  logic        b_valid;
  logic        b_ready, b_sout, b_en, b_last, b_busy;

  int n_checks;
  int n_fail;

  par_serializer #(
    .WIDTH      (32),
    .LSB_FIRST  (1'b0),
    .IDLE_LEVEL (1'b0)
  ) u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (a_din),
    .din_len   (a_len),
    .din_valid (a_valid),
`ifdef PAR_SERIALIZER_ABORT_EN
    .abort     (a_abort),
`endif
    .din_ready (a_ready),
    .sout      (a_sout),
    .sout_en   (a_en),
    .last      (a_last),
    .busy      (a_busy)
  );

  par_serializer #(
    .WIDTH      (8),
    .LSB_FIRST  (1'b1),
    .IDLE_LEVEL (1'b0)
  ) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (b_din),
    .din_len   (b_len),
    .din_valid (b_valid),
`ifdef PAR_SERIALIZER_ABORT_EN
    .abort     (1'b0),
`endif
    .din_ready (b_ready),
    .sout      (b_sout),
    .sout_en   (b_en),
    .last      (b_last),
    .busy      (b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed vectors are {sout, sout_en, last, busy, din_ready}

  task automatic test_reset();
    logic [3:0] obs;
    repeat (2) @(negedge clk);
    obs = {a_sout, a_en, a_last, a_busy};
    n_checks++;
    if (obs !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_a: got %b expected %b", obs, 4'b0000);
    end
    obs = {b_sout, b_en, b_last, b_busy};
    n_checks++;
    if (obs !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_b: got %b expected %b", obs, 4'b0000);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if ({a_ready, b_ready} !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_ready: got %b expected %b", {a_ready, b_ready}, 2'b11);
    end
  endtask

  task automatic test_msb32();
    logic [31:0] pat;
    logic [4:0]  obs, exp;
    pat = 32'hA500_0001;
    @(negedge clk);
    a_din = pat; a_len = 6'd0; a_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      a_valid = 1'b0;
      obs = {a_sout, a_en, a_last, a_busy, a_ready};
      exp = {pat[31-i], 1'b1, (i == 31), 1'b1, (i == 31)};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL msb32 bit %0d: got %b expected %b", i, obs, exp);
      end
    end
    @(negedge clk);
    obs = {a_sout, a_en, a_last, a_busy, a_ready};
    n_checks++;
    if (obs !== 5'b00001) begin
      n_fail++;
      $display("FAIL msb32_idle: got %b expected %b", obs, 5'b00001);
    end
  endtask

  task automatic test_lsb8();
    logic [3:0] seq;
    logic [4:0] obs, exp;
    seq = 4'b1101;
    @(negedge clk);
    b_din = 8'h0B; b_len = 4'd4; b_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      b_valid = 1'b0;
      obs = {b_sout, b_en, b_last, b_busy, b_ready};
      exp = {seq[3-i], 1'b1, (i == 3), 1'b1, (i == 3)};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL lsb8 bit %0d: got %b expected %b", i, obs, exp);
      end
    end
    @(negedge clk);
    obs = {b_sout, b_en, b_last, b_busy, b_ready};
    n_checks++;
    if (obs !== 5'b00001) begin
      n_fail++;
      $display("FAIL lsb8_idle: got %b expected %b", obs, 5'b00001);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] seq_sout, seq_last;
    logic [4:0] obs, exp;
    seq_sout = 5'b10101;
    seq_last = 5'b00101;
    @(negedge clk);
    a_din = 32'h0000_0005; a_len = 6'd3; a_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) begin
        a_din = 32'h0000_0001; a_len = 6'd2;
      end
      if (i == 3) begin
        a_valid = 1'b0;
      end
      obs = {a_sout, a_en, a_last, a_busy, a_ready};
      exp = {seq_sout[4-i], 1'b1, seq_last[4-i], 1'b1, seq_last[4-i]};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL b2b cycle %0d: got %b expected %b", i + 1, obs, exp);
      end
    end
    @(negedge clk);
    obs = {a_sout, a_en, a_last, a_busy, a_ready};
    n_checks++;
    if (obs !== 5'b00001) begin
      n_fail++;
      $display("FAIL b2b_idle: got %b expected %b", obs, 5'b00001);
    end
  endtask

  task automatic test_len1();
    logic [4:0] obs;
    @(negedge clk);
    a_din = 32'h0000_0001; a_len = 6'd1; a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    obs = {a_sout, a_en, a_last, a_busy, a_ready};
    n_checks++;
    if (obs !== 5'b11111) begin
      n_fail++;
      $display("FAIL len1_bit: got %b expected %b", obs, 5'b11111);
    end
    @(negedge clk);
    obs = {a_sout, a_en, a_last, a_busy, a_ready};
    n_checks++;
    if (obs !== 5'b00001) begin
      n_fail++;
      $display("FAIL len1_idle: got %b expected %b", obs, 5'b00001);
    end
  endtask

  task automatic test_len_over();
    logic [31:0] pat;
    logic [4:0]  obs, exp;
    pat = 32'h8000_0001;
    @(negedge clk);
    a_din = pat; a_len = 6'd40; a_valid = 1'b1;
    for (int i = 0; i < 33; i++) begin
      @(negedge clk);
      a_valid = 1'b0;
      obs = {a_sout, a_en, a_last, a_busy, a_ready};
      if (i < 32) begin
        exp = {pat[31-i], 1'b1, (i == 31), 1'b1, (i == 31)};
      end else begin
        exp = 5'b00001;
      end
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL len_over cycle %0d: got %b expected %b", i, obs, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0] obs, exp;
    @(negedge clk);
    a_din = 32'hFFFF_FFFF; a_len = 6'd0; a_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a_valid = 1'b0;
      obs = {a_sout, a_en, a_last, a_busy, a_ready};
      n_checks++;
      if (obs !== 5'b11010) begin
        n_fail++;
        $display("FAIL rstmid bit %0d: got %b expected %b", i, obs, 5'b11010);
      end
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({a_sout, a_en, a_last, a_busy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rstmid_async: got %b expected %b", {a_sout, a_en, a_last, a_busy}, 4'b0000);
    end
    @(negedge clk);
    n_checks++;
    if ({a_sout, a_en, a_last, a_busy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rstmid_held: got %b expected %b", {a_sout, a_en, a_last, a_busy}, 4'b0000);
    end
    rst_n = 1'b1;
    a_din = 32'h0000_0002; a_len = 6'd2; a_valid = 1'b1;
    #1;
    n_checks++;
    if (a_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_ready: got %b expected %b", a_ready, 1'b1);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a_valid = 1'b0;
      obs = {a_sout, a_en, a_last, a_busy, a_ready};
      case (i)
        0:       exp = 5'b11010;
        1:       exp = 5'b01111;
        default: exp = 5'b00001;
      endcase
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL rstmid_reload cycle %0d: got %b expected %b", i, obs, exp);
      end
    end
  endtask

`ifdef PAR_SERIALIZER_ABORT_EN
  task automatic test_abort();
    logic [4:0] obs;
    @(negedge clk);
    a_din = 32'hFFFF_FFFF; a_len = 6'd0; a_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      obs = {a_sout, a_en, a_last, a_busy, a_ready};
      n_checks++;
      if (obs !== 5'b11010) begin
        n_fail++;
        $display("FAIL abort_pre bit %0d: got %b expected %b", i, obs, 5'b11010);
      end
    end
    a_abort = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      obs = {a_sout, a_en, a_last, a_busy, a_ready};
      n_checks++;
      if (obs !== 5'b00000) begin
        n_fail++;
        $display("FAIL abort_held cycle %0d: got %b expected %b", i, obs, 5'b00000);
      end
    end
    a_abort = 1'b0;
    a_valid = 1'b0;
    #1;
    n_checks++;
    if (a_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_release_ready: got %b expected %b", a_ready, 1'b1);
    end
    @(negedge clk);
    obs = {a_sout, a_en, a_last, a_busy, a_ready};
    n_checks++;
    if (obs !== 5'b00001) begin
      n_fail++;
      $display("FAIL abort_idle: got %b expected %b", obs, 5'b00001);
    end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    a_din = '0; a_len = '0; a_valid = 1'b0; a_abort = 1'b0;
    b_din = '0; b_len = '0; b_valid = 1'b0;
    test_reset();
    test_msb32();
    test_lsb8();
    test_back_to_back();
    test_len1();
    test_len_over();
    test_reset_mid();
`ifdef PAR_SERIALIZER_ABORT_EN
    test_abort();
`endif
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
